// File: rtl/vga_timing_monitor.sv
// Passive observer of a VGA sync/RGB stream: measures line and frame geometry,
// checks it against the expected timing, and reports lock status and lit-pixel count.
module vga_timing_monitor #(
    parameter int H_TOTAL = 800,
    parameter int H_SYNC  = 96,
    parameter int V_TOTAL = 525,
    parameter int V_SYNC  = 2,
    parameter int CW      = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_en,
    input  logic          hsync,
    input  logic          vsync,
    input  logic [2:0]    red,
    input  logic [2:0]    green,
    input  logic [2:0]    blue,
    input  logic          clr_err,
    output logic [CW-1:0] h_total_o,
    output logic [CW-1:0] h_sync_o,
    output logic [CW-1:0] v_total_o,
    output logic [CW-1:0] v_sync_o,
    output logic [19:0]   lit_cnt,
    output logic [15:0]   frame_cnt,
    output logic          frame_done,
    output logic          locked,
    output logic          err_h,
    output logic          err_v
);

    typedef enum logic [1:0] {S_IDLE, S_SKIP, S_RUN} state_t;

    localparam logic [CW-1:0] CMAX  = {CW{1'b1}};
    localparam logic [CW-1:0] H_TOT = CW'(H_TOTAL);
    localparam logic [CW-1:0] H_SW  = CW'(H_SYNC);
    localparam logic [CW-1:0] V_TOT = CW'(V_TOTAL);
    localparam logic [CW-1:0] V_SW  = CW'(V_SYNC);
    localparam logic [19:0]   LMAX  = 20'hFFFFF;

    state_t        state, state_nx;
    logic          prev_h, prev_v, seen_hf, frame_bad;
    logic [CW-1:0] hcnt, hw, lines, vw;
    logic [19:0]   lit;
    logic [1:0]    good_cnt;
    logic          h_fall, h_rise, v_fall, v_rise, h_sat, lit_px;
    logic          meas_en, chk_en, run, fd, fail_h, fail_v;

    assign h_fall = pix_en & prev_h & ~hsync;
    assign h_rise = pix_en & ~prev_h & hsync;
    assign v_fall = pix_en & prev_v & ~vsync;
    assign v_rise = pix_en & ~prev_v & vsync;
    assign h_sat  = (hcnt == CMAX);
    assign lit_px = hsync & vsync & (|{red, green, blue});

    // First vsync fall only aligns us; the frame that follows is measured but
    // its checks wait for a full line so a partial line cannot raise an error.
    always_comb begin
        state_nx = state;
        meas_en  = 1'b0;
        chk_en   = 1'b0;
        run      = 1'b0;
        case (state)
            S_IDLE: begin
                if (v_fall) state_nx = S_SKIP;
            end
            S_SKIP: begin
                meas_en = 1'b1;
                chk_en  = seen_hf;
                if (v_fall) state_nx = S_RUN;
            end
            S_RUN: begin
                meas_en = 1'b1;
                chk_en  = 1'b1;
                run     = 1'b1;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign fd     = meas_en & v_fall;
    assign fail_h = pix_en & chk_en & ((h_fall & (hcnt != H_TOT)) |
                                       (h_rise & (hw != H_SW)) | h_sat);
    assign fail_v = (run & v_fall & (lines != V_TOT)) |
                    (chk_en & v_rise & (vw != V_SW));
    assign locked = (good_cnt == 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            seen_hf <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_SKIP && h_fall) seen_hf <= 1'b1;
        end
    end

    // Raw measurement counters run in every state; only the outputs are gated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_h <= 1'b1;
            prev_v <= 1'b1;
            hcnt   <= '0;
            hw     <= '0;
            lines  <= '0;
            vw     <= '0;
            lit    <= '0;
        end else if (pix_en) begin
            prev_h <= hsync;
            prev_v <= vsync;
            if (h_fall)     hcnt <= CW'(1);
            else if (!h_sat) hcnt <= hcnt + CW'(1);
            if (h_rise)                    hw <= '0;
            else if (!hsync && hw != CMAX) hw <= hw + CW'(1);
            // An hsync fall coincident with vsync fall opens the new frame.
            if (v_fall)                       lines <= h_fall ? CW'(1) : '0;
            else if (h_fall && lines != CMAX) lines <= lines + CW'(1);
            if (v_rise)                                vw <= '0;
            else if (h_fall && !vsync && vw != CMAX) vw <= vw + CW'(1);
            if (v_fall)                     lit <= '0;
            else if (lit_px && lit != LMAX) lit <= lit + 20'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_total_o  <= '0;
            h_sync_o   <= '0;
            v_total_o  <= '0;
            v_sync_o   <= '0;
            lit_cnt    <= '0;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= fd;
            frame_cnt  <= frame_cnt + 16'(fd);
            if (meas_en) begin
                if (h_fall) h_total_o <= hcnt;
                if (h_rise) h_sync_o  <= hw;
                if (v_rise) v_sync_o  <= vw;
                if (v_fall) begin
                    v_total_o <= lines;
                    lit_cnt   <= lit;
                end
            end
        end
    end

    // A new error outranks a simultaneous clear so no failure is ever lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_h     <= 1'b0;
            err_v     <= 1'b0;
            good_cnt  <= '0;
            frame_bad <= 1'b0;
        end else begin
            err_h <= fail_h | (err_h & ~(pix_en & clr_err));
            err_v <= fail_v | (err_v & ~(pix_en & clr_err));
            if (fail_h || fail_v)
                good_cnt <= '0;
            else if (fd && !frame_bad && good_cnt != 2'd2)
                good_cnt <= good_cnt + 2'd1;
            if (fd)                   frame_bad <= 1'b0;
            else if (fail_h || fail_v) frame_bad <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Randomised bench for vga_timing_monitor: an event-timestamp model predicts every output
// each clock, with literal checks pinning nominal geometry, errors, lock and reset.
module tb_vga_timing_monitor;

    localparam int HT = 40;
    localparam int HS = 5;
    localparam int VT = 12;
    localparam int VS = 2;
    localparam int CMAX = 4095;
    localparam int LMAX = 20'hFFFFF;

    logic        clk = 1'b0;
    logic        rst_n, pix_en, hsync, vsync, clr_err;
    logic [2:0]  red, green, blue;
    logic [11:0] h_total_o, h_sync_o, v_total_o, v_sync_o;
    logic [19:0] lit_cnt;
    logic [15:0] frame_cnt;
    logic        frame_done, locked, err_h, err_v;

    vga_timing_monitor #(.H_TOTAL(HT), .H_SYNC(HS), .V_TOTAL(VT), .V_SYNC(VS), .CW(12)) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue), .clr_err(clr_err),
        .h_total_o(h_total_o), .h_sync_o(h_sync_o), .v_total_o(v_total_o), .v_sync_o(v_sync_o),
        .lit_cnt(lit_cnt), .frame_cnt(frame_cnt), .frame_done(frame_done), .locked(locked),
        .err_h(err_h), .err_v(err_v)
    );

    always #10 clk = ~clk;

    int nCompared = 0;
    int nMismatched = 0;
    bit cmpOn = 0;

    // Model state: sample timestamps of sync events rather than counters.
    int n, vfalls, firstVfN, lastVf, litTot, litAtVf, good;
    bit ph, pv, badFrame;
    int hfQ[$];
    int eHT, eHS, eVT, eVS, eLit, eFc, eFd, eLk, eEh, eEv;

    function automatic int sat(input int x, input int m);
        return (x > m) ? m : x;
    endfunction

    function automatic int countHf(input int from, input int upto);
        int c = 0;
        foreach (hfQ[i]) if (hfQ[i] >= from && hfQ[i] < upto) c++;
        return c;
    endfunction

    task automatic checkOne(input string name, input int act, input int exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput();
        checkOne("h_total_o", int'(h_total_o), eHT);
        checkOne("h_sync_o", int'(h_sync_o), eHS);
        checkOne("v_total_o", int'(v_total_o), eVT);
        checkOne("v_sync_o", int'(v_sync_o), eVS);
        checkOne("lit_cnt", int'(lit_cnt), eLit);
        checkOne("frame_cnt", int'(frame_cnt), eFc);
        checkOne("frame_done", int'(frame_done), eFd);
        checkOne("locked", int'(locked), eLk);
        checkOne("err_h", int'(err_h), eEh);
        checkOne("err_v", int'(err_v), eEv);
    endtask

    always @(negedge clk) if (cmpOn) checkOutput();

    task automatic modelReset();
        n = 0; vfalls = 0; firstVfN = 0; lastVf = 0; litTot = 0; litAtVf = 0; good = 0;
        ph = 1; pv = 1; badFrame = 0;
        hfQ.delete();
        eHT = 0; eHS = 0; eVT = 0; eVS = 0; eLit = 0; eFc = 0; eFd = 0; eLk = 0; eEh = 0; eEv = 0;
    endtask

    task automatic modelSample(input bit h, input bit v, input logic [8:0] rgb, input bit clr);
        bit hfall, hrise, vfall, vrise, idle, chk, fd, failH, failV;
        int lastHf, hcnt, width, vcount;
        hfall = ph && !h;  hrise = !ph && h;
        vfall = pv && !v;  vrise = !pv && v;
        idle  = (vfalls == 0);
        chk   = (vfalls >= 2) || (vfalls == 1 && hfQ.size() > 0 && hfQ[$] > firstVfN);
        lastHf = (hfQ.size() > 0) ? hfQ[$] : 0;
        hcnt   = sat(n - lastHf, CMAX);
        width  = sat(n - lastHf, CMAX);
        vcount = sat(countHf(lastVf, n), CMAX);
        failH = chk && ((hfall && hcnt != HT) || (hrise && width != HS) || hcnt == CMAX);
        failV = (vfalls >= 2 && vfall && vcount != VT) || (chk && vrise && vcount != VS);
        fd = vfall && !idle;
        if (!idle) begin
            if (hfall) eHT = hcnt;
            if (hrise) eHS = width;
            if (vrise) eVS = vcount;
            if (vfall) begin
                eVT = vcount;
                eLit = sat(litTot - litAtVf, LMAX);
            end
        end
        eFd = fd;
        if (fd) eFc = (eFc + 1) & 16'hFFFF;
        eEh = failH || (eEh && !clr);
        eEv = failV || (eEv && !clr);
        if (failH || failV) good = 0;
        else if (fd && !badFrame && good < 2) good++;
        badFrame = fd ? 1'b0 : (badFrame || failH || failV);
        eLk = (good == 2);
        if (hfall) hfQ.push_back(n);
        if (vfall) begin
            if (vfalls == 0) firstVfN = n;
            if (vfalls < 2) vfalls++;
            lastVf = n;
            litAtVf = litTot;
        end
        if (h && v && rgb != 0) litTot++;
        ph = h; pv = v; n++;
    endtask

    task automatic idleClk();
        pix_en = 1'b0;
        hsync = 1'($urandom); vsync = 1'($urandom); clr_err = 1'($urandom);
        {red, green, blue} = 9'($urandom);
        eFd = 0;
        @(posedge clk); @(negedge clk); #1;
    endtask

    task automatic applyStimulus(input bit h, input bit v, input logic [8:0] rgb, input bit clr);
        int gap;
        gap = ($urandom_range(0, 3) == 0) ? 0 : (($urandom_range(0, 7) == 0) ? 2 : 1);
        for (int i = 0; i < gap; i++) idleClk();
        pix_en = 1'b1; hsync = h; vsync = v; clr_err = clr;
        {red, green, blue} = rgb;
        modelSample(h, v, rgb, clr);
        @(posedge clk); @(negedge clk); #1;
    endtask

    task automatic sendLine(input int l, input int len, input bit white, input int clrS);
        logic [8:0] rgb;
        bit active;
        for (int s = 0; s < len; s++) begin
            active = (l >= 3 && l <= 10 && s >= 10 && s < 36);
            if (white) rgb = active ? 9'h1FF : 9'h000;
            else rgb = ($urandom_range(0, 3) == 0) ? 9'h000 : 9'($urandom_range(1, 511));
            applyStimulus(s >= HS, l >= VS, rgb, s == clrS);
        end
    endtask

    task automatic sendLines(input int first, input int last, input bit white);
        for (int l = first; l <= last; l++) sendLine(l, HT, white, -1);
    endtask

    task automatic sendFrame(input int nLines, input bit white, input int clrLine, input int clrS);
        for (int l = 0; l < nLines; l++) sendLine(l, HT, white, (l == clrLine) ? clrS : -1);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        nMismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1; clr_err = 1'b0;
        red = '0; green = '0; blue = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        modelReset();
        cmpOn = 1;
        checkOutput();
        rst_n = 1'b1;

        $display("[TB] nominal frames and lock acquisition");
        sendFrame(VT, 0, -1, 0);
        sendFrame(VT, 0, -1, 0);
        checkOne("locked_before_3rd_vfall", int'(locked), 0);
        sendFrame(VT, 0, -1, 0);
        checkOne("locked_after_3rd_vfall", int'(locked), 1);
        checkOne("frame_cnt_nominal", int'(frame_cnt), 2);
        checkOne("h_total_nominal", int'(h_total_o), HT);
        checkOne("h_sync_nominal", int'(h_sync_o), HS);
        checkOne("v_total_nominal", int'(v_total_o), VT);
        checkOne("v_sync_nominal", int'(v_sync_o), VS);
        checkOne("err_h_nominal", int'(err_h), 0);
        checkOne("err_v_nominal", int'(err_v), 0);

        $display("[TB] short line, relock, clear");
        sendLines(0, 4, 0);
        sendLine(5, HT - 1, 0, -1);
        sendLine(6, HT, 0, -1);
        checkOne("err_h_short_line", int'(err_h), 1);
        checkOne("locked_short_line", int'(locked), 0);
        sendLines(7, VT - 1, 0);
        sendFrame(VT, 0, -1, 0);
        sendFrame(VT, 0, -1, 0);
        checkOne("locked_one_clean", int'(locked), 0);
        checkOne("err_h_sticky", int'(err_h), 1);
        sendFrame(VT, 0, 4, 20);
        checkOne("locked_two_clean", int'(locked), 1);
        checkOne("err_h_cleared", int'(err_h), 0);

        $display("[TB] full-white active region");
        sendFrame(VT, 1, -1, 0);
        sendFrame(VT, 0, -1, 0);
        checkOne("lit_cnt_white", int'(lit_cnt), 26 * 8);

        $display("[TB] hsync stuck high");
        for (int i = 0; i < 5000; i++) applyStimulus(1'b1, 1'b1, 9'h000, 1'b0);
        checkOne("err_h_stuck", int'(err_h), 1);
        checkOne("locked_stuck", int'(locked), 0);
        sendLine(0, HT, 0, -1);
        checkOne("h_total_saturated", int'(h_total_o), CMAX);
        sendLines(1, VT - 1, 0);
        sendFrame(VT, 0, -1, 0);

        $display("[TB] clear coincident with frame-length error");
        sendFrame(VT - 1, 0, -1, 0);
        sendFrame(VT, 0, 0, 0);
        checkOne("err_v_wins_over_clear", int'(err_v), 1);
        checkOne("err_h_cleared_again", int'(err_h), 0);

        $display("[TB] reset mid-frame");
        sendLines(0, 5, 0);
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOne("rst_h_total", int'(h_total_o), 0);
        checkOne("rst_frame_cnt", int'(frame_cnt), 0);
        checkOne("rst_lit_cnt", int'(lit_cnt), 0);
        checkOne("rst_locked", int'(locked), 0);
        checkOne("rst_err_v", int'(err_v), 0);
        @(negedge clk); #1;
        repeat (2) idleClk();
        rst_n = 1'b1;
        sendLines(6, VT - 1, 0);
        sendFrame(VT, 0, -1, 0);
        checkOne("frame_cnt_after_1st_vfall", int'(frame_cnt), 0);
        sendFrame(VT, 0, -1, 0);
        checkOne("frame_cnt_after_2nd_vfall", int'(frame_cnt), 1);
        sendFrame(VT, 0, -1, 0);
        checkOne("locked_after_reset", int'(locked), 1);

        cmpOn = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
